// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg -- shared framebuffer constants, types and address helper.
//
// Framebuffer geometry: 480 lines of 320 words, each word holding one 3-bit
// RGB color for a pair of adjacent 640-wide scan-out pixels.
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_ADDR_W = 18;
    localparam int COLOR_W   = 3;
    localparam int FB_LINES  = 480;

    localparam logic [FB_ADDR_W-1:0] FB_PAIRS_PER_LINE = 18'd320;
    localparam logic [FB_ADDR_W-1:0] FB_SIZE           = 18'd153600;

    // One buffered pixel write: 21 bits, address in the upper bits.
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]   data;
    } wr_entry_t;

    // What the single memory port does on the coming edge.
    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE,
        SLOT_DROP
    } slot_e;

    // Word address of a scan-out pixel pair. Widened to 18 bits before the
    // multiply so the largest value (153599) is not truncated.
    function automatic logic [FB_ADDR_W-1:0] read_addr(input logic [8:0] line,
                                                       input logic [9:0] offset);
        return FB_ADDR_W'(line) * FB_PAIRS_PER_LINE + FB_ADDR_W'(offset[9:1]);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// ---------------------------------------------------------------------------
// fb_wr_fifo -- write buffer between the pixel writer and the framebuffer.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   push          store push_entry at the tail (caller guarantees not full)
//   push_entry    {addr, data} to store
//   pop           drop the head entry (caller guarantees not empty)
//   head          oldest entry, valid whenever level > 0
//   level         occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  wr_entry_t  push_entry,
    input  logic       pop,
    output wr_entry_t  head,
    output logic [4:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array has no reset; reset empties the buffer by
    // clearing the pointers and level, so stale contents are never read.
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter -- single-port framebuffer arbiter between video scan-out reads
// and buffered pixel writes.
//
// Every even-offset visible pixel is a read slot: the pixel-pair word is
// fetched and its color reaches the DAC register two edges after issue.
// All other cycles drain the write buffer, one entry per cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   line, offset        scan-out position; active marks visible video
//   wr_valid/wr_ready   pixel write handshake; wr_addr, wr_data payload
//   mem_addr/we/wdata   registered framebuffer port; mem_rdata read data
//   color               registered pixel color to the DAC
//   fifo_level          write-buffer occupancy
// ---------------------------------------------------------------------------
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8:0]           line,
    input  logic [9:0]           offset,
    input  logic                 active,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [COLOR_W-1:0]   wr_data,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic                 mem_we,
    output logic [COLOR_W-1:0]   mem_wdata,
    input  logic [COLOR_W-1:0]   mem_rdata,
    output logic [COLOR_W-1:0]   color,
    output logic [4:0]           fifo_level
);

    wr_entry_t head;
    logic      push;
    logic      pop;
    logic      ready_q;     // low until the first edge after reset
    logic      rd_pending;  // a read was issued on the previous edge
    slot_e     slot;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry ('{addr: wr_addr, data: wr_data}),
        .pop        (pop),
        .head       (head),
        .level      (fifo_level)
    );

    assign wr_ready = ready_q & ~reset & (fifo_level < 5'(FIFO_DEPTH));
    assign push     = wr_valid & wr_ready;

    // NOTE: slot is assigned a default first so no path through this block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        slot = SLOT_IDLE;
        if (active && !offset[0]) begin
            slot = SLOT_READ;
        end else if (fifo_level != 5'd0) begin
            slot = (head.addr < FB_SIZE) ? SLOT_WRITE : SLOT_DROP;
        end
    end

    // Out-of-range entries are popped like valid ones, just never written.
    assign pop = (slot == SLOT_WRITE) || (slot == SLOT_DROP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q    <= 1'b0;
            rd_pending <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            color      <= '0;
        end else begin
            ready_q    <= 1'b1;
            rd_pending <= (slot == SLOT_READ);
            mem_we     <= 1'b0;

            case (slot)
                SLOT_READ: begin
                    mem_addr <= read_addr(line, offset);
                end
                SLOT_WRITE: begin
                    mem_addr  <= head.addr;
                    mem_wdata <= head.data;
                    mem_we    <= 1'b1;
                end
                default: begin
                    // idle or dropped entry: address and data hold
                end
            endcase

            // Blanking forces black and overrides any read still in flight.
            if (!active) begin
                color <= '0;
            end else if (rd_pending) begin
                color <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_arbiter -- directed self-checking bench for fb_arbiter.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  line;
    logic [9:0]  offset;
    logic        active;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] wr_addr;
    logic [2:0]  wr_data;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;
    logic [2:0]  color;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    fb_arbiter #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .line       (line),
        .offset     (offset),
        .active     (active),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .color      (color),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " color"},      32'(color),      0);
        check({tag, " mem_we"},     32'(mem_we),     0);
        check({tag, " mem_addr"},   32'(mem_addr),   0);
        check({tag, " mem_wdata"},  32'(mem_wdata),  0);
        check({tag, " fifo_level"}, 32'(fifo_level), 0);
        check({tag, " wr_ready"},   32'(wr_ready),   0);
    endtask

    initial begin
        reset     = 1'b1;
        line      = '0;
        offset    = '0;
        active    = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        mem_rdata = '0;

        // Reset held for 40 ns.
        #40;
        check_all_zero("reset");
        #2;
        reset = 1'b0;
        #1;
        check("wr_ready before first edge", 32'(wr_ready), 0);
        tick();
        check("wr_ready after release", 32'(wr_ready), 1);

        // Read slot: line 2, offset 10 -> 2*320 + 5 = 645.
        active    = 1'b1;
        line      = 9'd2;
        offset    = 10'd10;
        mem_rdata = 3'b101;
        tick();
        check("read mem_addr", 32'(mem_addr), 645);
        check("read mem_we", 32'(mem_we), 0);
        check("color before load", 32'(color), 0);
        offset = 10'd11;
        tick();
        check("color loaded", 32'(color), 3'b101);
        check("idle mem_addr holds", 32'(mem_addr), 645);
        mem_rdata = 3'b010;
        tick();
        check("color holds", 32'(color), 3'b101);

        // Largest read address: 479*320 + 319.
        line   = 9'd479;
        offset = 10'd638;
        tick();
        check("max read addr", 32'(mem_addr), 153599);

        // Blanking write: one entry drains on the following edge.
        active   = 1'b0;
        line     = '0;
        offset   = '0;
        wr_valid = 1'b1;
        wr_addr  = 18'd100;
        wr_data  = 3'b110;
        tick();
        check("write queued level", 32'(fifo_level), 1);
        check("write not same edge", 32'(mem_we), 0);
        check("blank color", 32'(color), 0);
        wr_valid = 1'b0;
        tick();
        check("write mem_we", 32'(mem_we), 1);
        check("write mem_addr", 32'(mem_addr), 100);
        check("write mem_wdata", 32'(mem_wdata), 3'b110);
        check("write level drained", 32'(fifo_level), 0);
        tick();
        check("idle mem_we", 32'(mem_we), 0);
        check("idle addr holds", 32'(mem_addr), 100);

        // Out-of-range write is discarded; the next one is unaffected.
        wr_valid = 1'b1;
        wr_addr  = 18'd153600;
        wr_data  = 3'b111;
        tick();
        wr_addr = 18'd200;
        wr_data = 3'b011;
        tick();
        check("drop mem_we", 32'(mem_we), 0);
        check("drop addr holds", 32'(mem_addr), 100);
        check("drop wdata holds", 32'(mem_wdata), 3'b110);
        check("drop push+pop level", 32'(fifo_level), 1);
        wr_valid = 1'b0;
        tick();
        check("after drop mem_we", 32'(mem_we), 1);
        check("after drop mem_addr", 32'(mem_addr), 200);
        check("after drop wdata", 32'(mem_wdata), 3'b011);

        // Continuous reads fill the buffer; writes then drain on odd offsets.
        active    = 1'b1;
        offset    = 10'd0;
        mem_rdata = 3'b001;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 18'(1000 + i);
            wr_data  = 3'(i + 1);
            tick();
            check("fill mem_we", 32'(mem_we), 0);
            check("fill level", 32'(fifo_level), 32'(i + 1));
        end
        check("full wr_ready", 32'(wr_ready), 0);
        wr_addr = 18'd1004;
        wr_data = 3'd5;
        tick();
        check("full holds level", 32'(fifo_level), 4);
        offset = 10'd1;
        tick();
        check("drain0 mem_we", 32'(mem_we), 1);
        check("drain0 mem_addr", 32'(mem_addr), 1000);
        check("drain0 mem_wdata", 32'(mem_wdata), 1);
        check("drain0 level", 32'(fifo_level), 3);
        check("space wr_ready", 32'(wr_ready), 1);
        offset = 10'd2;
        tick();
        check("refill level", 32'(fifo_level), 4);
        check("refill mem_we", 32'(mem_we), 0);
        wr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            offset = 10'(2 * k + 1);
            tick();
            check("drain mem_we", 32'(mem_we), 1);
            check("drain mem_addr", 32'(mem_addr), 32'(1000 + k));
            check("drain mem_wdata", 32'(mem_wdata), 32'(k + 1));
            offset = 10'(2 * k + 2);
            tick();
            check("read between mem_we", 32'(mem_we), 0);
            check("read between mem_addr", 32'(mem_addr), 32'(k + 1));
        end
        check("drained level", 32'(fifo_level), 0);

        // Reset with three entries buffered and a read in flight.
        offset = 10'd0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 18'(2000 + i);
            wr_data  = 3'd7;
            tick();
        end
        wr_valid = 1'b0;
        check("pre-reset level", 32'(fifo_level), 3);
        reset = 1'b1;
        #1;
        check_all_zero("mid reset");
        tick();
        reset     = 1'b0;
        offset    = 10'd1;
        mem_rdata = 3'b111;
        tick();
        check("post reset wr_ready", 32'(wr_ready), 1);
        check("post reset color", 32'(color), 0);
        check("post reset mem_we", 32'(mem_we), 0);
        check("post reset level", 32'(fifo_level), 0);
        active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no stale write", 32'(mem_we), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
